// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequential initiator for the combinational 64-bit LEGv8 ALU.
// Accepts one R-format request at a time, drives the operands one cycle before the
// op code, waits a per-class settle latency, then holds a registered response.
// Optional build macro: ALU_OP_COUNTER_EN (adds the op_count response counter).
module alu_issue_ctrl #(
   parameter int ADD_LAT = 1,
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [10:0] req_opcode,
   input  logic [63:0] req_a,
   input  logic [63:0] req_b,
   output logic [63:0] alu_a_in,
   output logic [63:0] alu_b_in,
   output logic [2:0]  alu_operation,
   input  logic [63:0] alu_result,
   input  logic        alu_zero,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_result,
   output logic        rsp_zero,
   output logic        rsp_illegal,
   output logic        rsp_div_zero,
   output logic [31:0] op_count
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SETUP = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_DIV = 3'b011;

   localparam int unsigned ADD_L = (ADD_LAT < 1) ? 1 : (ADD_LAT > 15) ? 15 : ADD_LAT;
   localparam int unsigned MUL_L = (MUL_LAT < 1) ? 1 : (MUL_LAT > 15) ? 15 : MUL_LAT;
   localparam int unsigned DIV_L = (DIV_LAT < 1) ? 1 : (DIV_LAT > 15) ? 15 : DIV_LAT;

   // Counter holds remaining WAIT cycles minus one, so zero marks the capture cycle
   localparam logic [3:0] ADD_CNT = 4'(ADD_L - 1);
   localparam logic [3:0] MUL_CNT = 4'(MUL_L - 1);
   localparam logic [3:0] DIV_CNT = 4'(DIV_L - 1);

   logic [1:0]  state_q,   state_d;
   logic [63:0] a_q,       a_d;
   logic [63:0] b_q,       b_d;
   logic [2:0]  op_q,      op_d;
   logic [2:0]  alu_op_q,  alu_op_d;
   logic [3:0]  cnt_q,     cnt_d;
   logic [63:0] res_q,     res_d;
   logic        zero_q,    zero_d;
   logic        ill_q,     ill_d;
   logic        dz_q,      dz_d;

   logic [2:0]  dec_op;
   logic        dec_legal;

   // Opcode decode of the incoming request
   always_comb begin
      dec_op    = 3'b000;
      dec_legal = 1'b1;
      case (req_opcode)
         11'b10001011000: dec_op = OP_ADD;
         11'b11001011000: dec_op = OP_SUB;
         11'b10011011000: dec_op = OP_MUL;
         11'b10011010110: dec_op = OP_DIV;
         default:         dec_legal = 1'b0;
      endcase
   end

   // Next-state logic for the issue FSM and its datapath registers
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      alu_op_d = alu_op_q;
      cnt_d    = cnt_q;
      res_d    = res_q;
      zero_d   = zero_q;
      ill_d    = ill_q;
      dz_d     = dz_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (!dec_legal || (dec_op == OP_DIV && req_b == '0)) begin
                  // Rejected requests answer directly without touching the ALU inputs
                  res_d   = '0;
                  zero_d  = 1'b1;
                  ill_d   = !dec_legal;
                  dz_d    = dec_legal;
                  state_d = S_RESP;
               end else begin
                  a_d     = req_a;
                  b_d     = req_b;
                  op_d    = dec_op;
                  state_d = S_SETUP;
               end
            end
         end
         S_SETUP: begin
            alu_op_d = op_q;
            case (op_q)
               OP_MUL:  cnt_d = MUL_CNT;
               OP_DIV:  cnt_d = DIV_CNT;
               default: cnt_d = ADD_CNT;
            endcase
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               res_d    = alu_result;
               zero_d   = alu_zero;
               ill_d    = 1'b0;
               dz_d     = 1'b0;
               alu_op_d = 3'b000;
               state_d  = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            if (rsp_ready) state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         alu_op_q <= '0;
         cnt_q    <= '0;
         res_q    <= '0;
         zero_q   <= 1'b0;
         ill_q    <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         alu_op_q <= alu_op_d;
         cnt_q    <= cnt_d;
         res_q    <= res_d;
         zero_q   <= zero_d;
         ill_q    <= ill_d;
         dz_q     <= dz_d;
      end
   end

   assign req_ready     = (state_q == S_IDLE);
   assign rsp_valid     = (state_q == S_RESP);
   assign alu_a_in      = a_q;
   assign alu_b_in      = b_q;
   assign alu_operation = alu_op_q;
   assign rsp_result    = res_q;
   assign rsp_zero      = zero_q;
   assign rsp_illegal   = ill_q;
   assign rsp_div_zero  = dz_q;

`ifdef ALU_OP_COUNTER_EN
   logic [31:0] op_count_q;

   // Count every completed response handshake, wrapping naturally
   always_ff @(posedge clk) begin
      if (reset)                       op_count_q <= '0;
      else if (rsp_valid && rsp_ready) op_count_q <= op_count_q + 32'd1;
   end

   assign op_count = op_count_q;
`else
   assign op_count = '0;
`endif

endmodule
